accu_seq_ctrl: RTL and testbench

- Sequencer that drives the one-accumulator FSM without manual button presses.
- Latches a bit pattern and a length, clears the accumulator, then steps it one bit per slot with a paced `acc_next` pulse.
- After each bit it samples the accumulator output and counts hits.
- Sits between the switch/button inputs and the accumulator instance on the board top level.

---
 rtl/accu_seq_ctrl_if.sv | 10 +
 rtl/accu_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_accu_seq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/accu_seq_ctrl_if.sv
// rtl/accu_seq_ctrl_if.sv - link between the sequencer and the one-accumulator FSM
interface accu_seq_ctrl_if;
    logic acc_rst;
    logic acc_next;
    logic acc_in;
    logic acc_out;

    modport master (output acc_rst, output acc_next, output acc_in, input acc_out);
    modport slave  (input acc_rst, input acc_next, input acc_in, output acc_out);
endinterface

// File: rtl/accu_seq_ctrl.sv
// rtl/accu_seq_ctrl.sv - paced bit sequencer driving the accumulator and counting its hits
// Optional ACCU_SEQ_TRACE_EN adds a per-bit trace of sampled acc_out.
module accu_seq_ctrl #(
    parameter int W         = 16,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     pattern,
    input  logic [CNT_W-1:0] len,
    accu_seq_ctrl_if.master  acc,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_index,
    output logic [CNT_W-1:0] hit_count
`ifdef ACCU_SEQ_TRACE_EN
    ,
    output logic [W-1:0]     trace
`endif
);

    localparam int PG_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int PH_W   = (PG_MAX > 1) ? $clog2(PG_MAX) : 1;
    localparam logic [CNT_W-1:0] W_CNT    = CNT_W'(W);
    localparam logic [PH_W-1:0]  PULSE_LST = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0]  GAP_LST   = PH_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRIVE  = 3'd2,
        GAP    = 3'd3,
        SAMPLE = 3'd4,
        FIN    = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [PH_W-1:0]  ph_cnt;
    logic [W-1:0]     pat_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] bit_index_n;
    logic             accept;
    logic             last_bit;
    logic             bit_n;

    assign len_eff  = (len > W_CNT) ? W_CNT : len;
    assign accept   = (state == IDLE) && start && !abort;
    assign last_bit = (bit_index == len_q - CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_index_n = bit_index;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n     = LOAD;
                    bit_index_n = '0;
                end
            end
            LOAD: begin
                if (abort)              state_n = IDLE;
                else if (len_q == '0)   state_n = FIN;
                else                    state_n = DRIVE;
            end
            DRIVE: begin
                if (abort)                   state_n = IDLE;
                else if (ph_cnt == PULSE_LST) state_n = GAP;
            end
            GAP: begin
                if (abort)                 state_n = IDLE;
                else if (ph_cnt == GAP_LST) state_n = SAMPLE;
            end
            SAMPLE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (last_bit) begin
                    state_n = FIN;
                end else begin
                    state_n     = DRIVE;
                    bit_index_n = bit_index + CNT_W'(1);
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bit presented during the upcoming slot; bit_index_n already points at it.
    always_comb begin
        bit_n = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (bit_index_n == CNT_W'(i)) bit_n = pat_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_cnt       <= '0;
            pat_q        <= '0;
            len_q        <= '0;
            bit_index    <= '0;
            hit_count    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            acc.acc_rst  <= 1'b0;
            acc.acc_next <= 1'b0;
            acc.acc_in   <= 1'b0;
        end else begin
            if (accept) begin
                pat_q     <= pattern;
                len_q     <= len_eff;
                hit_count <= '0;
            end
            if (state == SAMPLE && !abort && acc.acc_out && hit_count != '1) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            bit_index <= bit_index_n;

            // Phase counter restarts on every entry so each phase runs its full length.
            if ((state_n == DRIVE || state_n == GAP) && state_n == state) begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end else begin
                ph_cnt <= '0;
            end

            acc.acc_rst  <= (state_n == LOAD);
            acc.acc_next <= (state_n == DRIVE);
            busy         <= (state_n == LOAD) || (state_n == DRIVE) ||
                            (state_n == GAP)  || (state_n == SAMPLE);
            done         <= (state_n == FIN);
            acc.acc_in   <= ((state_n == DRIVE) || (state_n == GAP) || (state_n == SAMPLE))
                            ? bit_n : 1'b0;
        end
    end

`ifdef ACCU_SEQ_TRACE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace <= '0;
        end else if (state_n == LOAD) begin
            trace <= '0;
        end else if (state == SAMPLE && !abort) begin
            for (int i = 0; i < W; i++) begin
                if (bit_index == CNT_W'(i)) trace[i] <= acc.acc_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accu_seq_ctrl.sv
// tb/tb_accu_seq_ctrl.sv - self-checking bench for accu_seq_ctrl with a behavioural accumulator peer
module tb_accu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic [4:0]  bit_index;
    logic [4:0]  hit_count;
`ifdef ACCU_SEQ_TRACE_EN
    logic [15:0] trace;
`endif

    int checks = 0;
    int errors = 0;

    accu_seq_ctrl_if acc ();

    accu_seq_ctrl #(.W(16), .PULSE_CYC(2), .GAP_CYC(4), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .len       (len),
        .acc       (acc.master),
        .busy      (busy),
        .done      (done),
        .bit_index (bit_index),
        .hit_count (hit_count)
`ifdef ACCU_SEQ_TRACE_EN
        ,
        .trace     (trace)
`endif
    );

    always #5 clk = ~clk;

    // Accumulator peer: 2-flop edge detector, counts consecutive ones, output high on every 4th.
    logic s1 = 1'b0, s2 = 1'b0;
    int   run_cnt = 0;
    always @(posedge clk) begin
        s1 <= acc.acc_next;
        s2 <= s1;
        if (acc.acc_rst) run_cnt <= 0;
        else if (s1 && !s2) run_cnt <= acc.acc_in ? ((run_cnt == 4) ? 1 : run_cnt + 1) : 0;
    end
    assign acc.acc_out = (run_cnt == 4);

    typedef struct {
        logic [15:0] pat;
        logic [4:0]  ln;
        int          exp_hits;
        int          exp_lat;
        int          exp_bi;
        int          exp_nexts;
        logic [15:0] exp_trace;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void ref_run(input logic [15:0] p, input int n,
                                    output int hits, output logic [15:0] tr);
        int ones;
        hits = 0;
        tr   = '0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            ones = p[i] ? ones + 1 : 0;
            if (ones > 0 && ones % 4 == 0) begin
                hits++;
                tr[i] = 1'b1;
            end
        end
    endfunction

    task automatic run_one(input vec_t v, input string nm);
        int   lat, nexts, rsts, k;
        logic seen_done, stable_ok, bits_ok, held, prev_next;
        @(posedge clk); #1;
        pattern = v.pat;
        len     = v.ln;
        start   = 1'b1;
        lat = 0; nexts = 0; rsts = 0; k = 0;
        seen_done = 1'b0; stable_ok = 1'b1; bits_ok = 1'b1; held = 1'b0; prev_next = 1'b0;
        while (!seen_done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                start   = 1'b0;
                pattern = ~v.pat;
                len     = 5'd3;
            end
            if (lat == 10 && busy) start = 1'b1;
            if (lat == 11) start = 1'b0;
            if (acc.acc_next) nexts++;
            if (acc.acc_rst) rsts++;
            if (acc.acc_next && !prev_next) begin
                held = acc.acc_in;
                if (k < 16 && acc.acc_in !== v.pat[k]) bits_ok = 1'b0;
                k++;
            end else if (busy && k > 0 && acc.acc_in !== held) begin
                stable_ok = 1'b0;
            end
            prev_next = acc.acc_next;
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        chk({nm, " done_seen"}, int'(seen_done), 1);
        chk({nm, " latency"}, lat, v.exp_lat);
        chk({nm, " hit_count"}, int'(hit_count), v.exp_hits);
        chk({nm, " bit_index"}, int'(bit_index), v.exp_bi);
        chk({nm, " acc_next_cycles"}, nexts, v.exp_nexts);
        chk({nm, " acc_rst_cycles"}, rsts, 1);
        chk({nm, " acc_in_bits"}, int'(bits_ok), 1);
        chk({nm, " acc_in_stable"}, int'(stable_ok), 1);
`ifdef ACCU_SEQ_TRACE_EN
        chk({nm, " trace"}, int'(trace), int'(v.exp_trace));
`endif
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, int'({done, busy}), 0);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " hit_hold_idle"}, int'(hit_count), v.exp_hits);
    endtask

    initial begin : main
        vec_t v;
        int   h, n, tmo, ab_hits;
        logic [15:0] tr;
        logic prev;

        tbl[0] = '{16'h00FF, 5'd8,  2, 58,  7,  16, 16'h0088};
        tbl[1] = '{16'h001F, 5'd5,  1, 37,  4,  10, 16'h0008};
        tbl[2] = '{16'h0000, 5'd20, 0, 114, 15, 32, 16'h0000};
        tbl[3] = '{16'hA5A5, 5'd0,  0, 2,   0,  0,  16'h0000};

        reset = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({busy, done, acc.acc_rst, acc.acc_next, acc.acc_in, bit_index, hit_count}), 0);
        reset = 1'b0;

        // Reset in the DRIVE phase of bit 4, when hit_count already holds 1.
        @(posedge clk); #1;
        pattern = 16'h00FF; len = 5'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tmo = 0;
        while (!(acc.acc_next && bit_index == 5'd4) && tmo < 100) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("reach_drive_bit4", int'(tmo < 100), 1);
        chk("hit_before_reset", int'(hit_count), 1);
        reset = 1'b1;
        #1;
        chk("reset_mid_drive", int'({busy, done, acc.acc_rst, acc.acc_next, acc.acc_in, bit_index, hit_count}), 0);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i], $sformatf("vec%0d", i));
        end

        // start and abort together in IDLE must not launch a run.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; pattern = 16'h000F; len = 5'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("start_abort_idle", int'({busy, acc.acc_rst, acc.acc_next}), 0);
        start = 1'b0; abort = 1'b0;
        v = '{16'h000F, 5'd4, 1, 30, 3, 8, 16'h0008};
        run_one(v, "after_start_abort");

        // Abort in the GAP of bit 5, with a stray start pulse mid-run.
        @(posedge clk); #1;
        pattern = 16'hFFFF; len = 5'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tmo = 0; prev = 1'b0;
        while (tmo < 200) begin
            @(posedge clk); #1;
            tmo++;
            if (tmo == 12) start = 1'b1;
            if (tmo == 13) start = 1'b0;
            if (prev && !acc.acc_next && bit_index == 5'd5) break;
            prev = acc.acc_next;
        end
        chk("reach_gap_bit5", int'(tmo < 200), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        ref_run(16'hFFFF, 5, ab_hits, tr);
        chk("abort_idle", int'({busy, done, acc.acc_next, acc.acc_in}), 0);
        chk("abort_hits", int'(hit_count), ab_hits);
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        chk("abort_no_done", n, 0);
`ifdef ACCU_SEQ_TRACE_EN
        chk("abort_trace", int'(trace), int'(tr));
`endif

        for (int r = 0; r < 16; r++) begin
            v.pat = 16'($urandom());
            if (r % 3 == 0) v.pat = v.pat | 16'h0F0F;
            v.ln  = 5'($urandom_range(0, 31));
            n     = (int'(v.ln) > 16) ? 16 : int'(v.ln);
            ref_run(v.pat, n, h, tr);
            v.exp_hits  = h;
            v.exp_trace = tr;
            v.exp_lat   = 2 + 7 * n;
            v.exp_bi    = (n > 0) ? n - 1 : 0;
            v.exp_nexts = 2 * n;
            run_one(v, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
